// File: rtl/tangram_input_ctrl.sv
// Button/switch front end for the tangram display: sync, debounce, auto-repeat,
// rotate-vs-move arbitration, and frame-aligned single-cycle command pulses.
module tangram_input_ctrl #(
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 4,
    parameter int CNT_W        = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [2:0] sel_sw,
    input  logic [4:0] btn_raw,
    output logic [7:0] btn,
    output logic [3:0] move,
    output logic       rotate,
    output logic       held
);
    localparam int FC_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    typedef enum logic [1:0] {IDLE, DELAY, RPT} mstate_t;

    logic [4:0]       btn_p0, btn_p1;
    logic [2:0]       sel_p0, sel_p1;
    logic [CNT_W-1:0] db_cnt [5];
    logic [4:0]       db;
    logic [4:0]       press;
    mstate_t          st [4];
    logic [FC_W-1:0]  fcnt [4];
    logic [3:0]       pend;
    logic             rot_pend;
    logic [2:0]       sel_q;
    logic [3:0]       go_mv, clr_mv;
    logic             go_rot, clr_rot;

    // Stage p0/p1: two-flop synchronisers
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            sel_p0 <= '0;
            sel_p1 <= '0;
        end else begin
            btn_p0 <= btn_raw;
            btn_p1 <= btn_p0;
            sel_p0 <= sel_sw;
            sel_p1 <= sel_p0;
        end
    end

    // Debounce: count consecutive cycles where the input disagrees with the level
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
            db    <= '0;
            press <= '0;
        end else begin
            press <= '0;
            for (int i = 0; i < 5; i++) begin
                if (btn_p1[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    db[i]     <= btn_p1[i];
                    db_cnt[i] <= '0;
                    press[i]  <= btn_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Issue decision uses the flags as they stood before this tick, so a
    // press landing on the tick waits for the following one.
    always_comb begin
        go_mv   = '0;
        clr_mv  = '0;
        go_rot  = 1'b0;
        clr_rot = 1'b0;
        if (frame_tick) begin
            if (sel_q == 3'd0) begin
                clr_mv  = pend;
                clr_rot = rot_pend;
            end else if (rot_pend) begin
                go_rot  = 1'b1;
                clr_rot = 1'b1;
            end else begin
                clr_mv = pend;
                go_mv  = pend;
                if (pend[0] && pend[1]) go_mv[1:0] = 2'b00;
                if (pend[2] && pend[3]) go_mv[3:2] = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                st[i]   <= IDLE;
                fcnt[i] <= '0;
            end
            pend     <= '0;
            rot_pend <= 1'b0;
            sel_q    <= '0;
            btn      <= '0;
            move     <= '0;
            rotate   <= 1'b0;
            held     <= 1'b0;
        end else begin
            move   <= go_mv;
            rotate <= go_rot;
            held   <= |db;
            if (frame_tick && !held) begin
                sel_q <= sel_p1;
                btn   <= (sel_p1 == 3'd0) ? 8'd0 : (8'd1 << sel_p1);
            end
            if (press[4])     rot_pend <= 1'b1;
            else if (clr_rot) rot_pend <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!db[i]) begin
                    st[i]   <= IDLE;
                    fcnt[i] <= '0;
                    pend[i] <= 1'b0;
                end else begin
                    pend[i] <= pend[i] & ~clr_mv[i];
                    case (st[i])
                        IDLE: if (press[i]) begin
                            pend[i] <= 1'b1;
                            st[i]   <= DELAY;
                            fcnt[i] <= '0;
                        end
                        DELAY: if (frame_tick) begin
                            if (fcnt[i] + FC_W'(1) == FC_W'(REPEAT_DELAY)) begin
                                pend[i] <= 1'b1;
                                st[i]   <= RPT;
                                fcnt[i] <= '0;
                            end else begin
                                fcnt[i] <= fcnt[i] + FC_W'(1);
                            end
                        end
                        RPT: if (frame_tick) begin
                            if (fcnt[i] + FC_W'(1) == FC_W'(REPEAT_RATE)) begin
                                pend[i] <= 1'b1;
                                fcnt[i] <= '0;
                            end else begin
                                fcnt[i] <= fcnt[i] + FC_W'(1);
                            end
                        end
                        default: st[i] <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_tangram_input_ctrl.sv
// Directed bench for tangram_input_ctrl with small debounce/repeat parameters.
module tb_tangram_input_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [2:0] sel_sw;
    logic [4:0] btn_raw;
    logic [7:0] btn;
    logic [3:0] move;
    logic       rotate;
    logic       held;

    int checks   = 0;
    int failures = 0;

    tangram_input_ctrl #(
        .DB_CYCLES(4), .REPEAT_DELAY(3), .REPEAT_RATE(2), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .sel_sw(sel_sw),
        .btn_raw(btn_raw), .btn(btn), .move(move), .rotate(rotate), .held(held)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic frame();
        cyc(19);
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_mv;
        rst = 1'b1; frame_tick = 1'b0; sel_sw = 3'd3; btn_raw = 5'b0;
        cyc(3);
        chk("rst_btn", btn, 8'h00);
        chk("rst_move", move, 4'h0);
        chk("rst_rotate", rotate, 1'b0);
        chk("rst_held", held, 1'b0);
        rst = 1'b0;
        cyc(5);
        frame();
        chk("sel3_btn", btn, 8'b0000_1000);
        chk("sel3_move", move, 4'h0);
        chk("sel3_rotate", rotate, 1'b0);
        chk("sel3_held", held, 1'b0);

        // Short up press spanning one tick
        cyc(10);
        btn_raw = 5'b00001;
        cyc(8);
        btn_raw = 5'b00000;
        tick();
        chk("up_pulse", move, 4'b0001);
        cyc(1);
        chk("up_width", move, 4'b0000);
        frame();
        chk("up_none1", move, 4'b0000);
        frame();
        chk("up_none2", move, 4'b0000);
        chk("up_held", held, 1'b0);

        // Right held for ten frames: auto-repeat
        btn_raw = 5'b01000;
        for (int k = 1; k <= 10; k++) begin
            frame();
            exp_mv = (k == 1 || k == 4 || k == 6 || k == 8 || k == 10) ? 4'b1000 : 4'b0000;
            chk($sformatf("right_tick%0d", k), move, exp_mv);
            if (k == 1) begin
                cyc(1);
                chk("right_width", move, 4'b0000);
            end
            if (k == 5) chk("right_held", held, 1'b1);
        end
        btn_raw = 5'b00000;
        frame();
        chk("right_rel1", move, 4'b0000);
        frame();
        chk("right_rel2", move, 4'b0000);

        // Rotate and left together: rotate first, move next tick
        btn_raw = 5'b10100;
        frame();
        chk("rot_N", rotate, 1'b1);
        chk("rot_N_move", move, 4'b0000);
        cyc(1);
        chk("rot_width", rotate, 1'b0);
        frame();
        chk("rot_N1_move", move, 4'b0100);
        chk("rot_N1_rot", rotate, 1'b0);
        btn_raw = 5'b10000;
        frame();
        chk("rot_once1", rotate, 1'b0);
        chk("rot_once_mv", move, 4'b0000);
        frame();
        chk("rot_once2", rotate, 1'b0);
        btn_raw = 5'b00000;
        frame();
        chk("rot_rel", rotate, 1'b0);

        // Bounce on up never debounces
        for (int k = 0; k < 10; k++) begin
            btn_raw[0] = ~btn_raw[0];
            cyc(2);
        end
        frame();
        chk("bounce_move", move, 4'b0000);
        chk("bounce_held", held, 1'b0);
        frame();
        chk("bounce_move2", move, 4'b0000);

        // Up and down together cancel
        btn_raw = 5'b00011;
        for (int k = 1; k <= 5; k++) begin
            frame();
            chk($sformatf("updn_tick%0d", k), move, 4'b0000);
        end
        btn_raw = 5'b00000;
        frame();
        chk("updn_rel", move, 4'b0000);

        // Selection change deferred while left held
        btn_raw = 5'b00100;
        cyc(10);
        sel_sw = 3'd5;
        frame();
        chk("defer_btn1", btn, 8'b0000_1000);
        chk("defer_move", move, 4'b0100);
        frame();
        chk("defer_btn2", btn, 8'b0000_1000);
        btn_raw = 5'b00000;
        frame();
        chk("sel5_btn", btn, 8'b0010_0000);

        // Reset with a move pending discards it
        btn_raw = 5'b00010;
        cyc(10);
        rst = 1'b1;
        btn_raw = 5'b00000;
        cyc(2);
        chk("mid_rst_btn", btn, 8'h00);
        chk("mid_rst_move", move, 4'h0);
        chk("mid_rst_held", held, 1'b0);
        rst = 1'b0;
        frame();
        chk("post_rst_move", move, 4'h0);
        chk("post_rst_btn", btn, 8'b0010_0000);
        frame();
        chk("post_rst_move2", move, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
